// File: rtl/reg_alu_pkg.sv
// Shared definitions for the pipelined register-file/ALU block: opcode width
// and the fixed opcode encoding.
package reg_alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_PASS = 3'd7
  } alu_op_e;

endpackage

// File: rtl/reg_alu_pipe_alu_core.sv
// Combinational eight-operation ALU. Shifts use only the low log2(WIDTH) bits
// of B; cout is carry for ADD, no-borrow for SUB, and 0 otherwise.
module alu_core
  import reg_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero
);

  localparam int SH_W = $clog2(WIDTH);

  logic [WIDTH:0]   sum;
  logic [SH_W-1:0]  shamt;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    shamt  = b[SH_W-1:0];
    result = '0;
    cout   = 1'b0;
    case (alu_op_e'(op))
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        cout   = sum[WIDTH];
      end
      OP_SUB: begin
        result = a - b;
        cout   = (a >= b);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL:  result = a << shamt;
      OP_SHR:  result = a >> shamt;
      OP_PASS: result = a;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/reg_alu_pipe.sv
// Two-stage register-file/ALU pipeline: operand read with write-back
// forwarding in stage 1, ALU evaluation plus output/write-back registers in stage 2.
module reg_alu_pipe #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3,
  parameter int OP_W   = reg_alu_pkg::OP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              sel,
  input  logic              wr,
  input  logic [OP_W-1:0]   op,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  d_in,
  output logic              out_valid,
  output logic [WIDTH-1:0]  d_out_a,
  output logic [WIDTH-1:0]  d_out_b,
  output logic [WIDTH-1:0]  result,
  output logic              cout,
  output logic              zero
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0]  rf_q [DEPTH];
  logic [WIDTH-1:0]  rf_d [DEPTH];

  logic              ex_valid_q, ex_valid_d;
  logic              ex_sel_q, ex_sel_d;
  logic              ex_wr_q, ex_wr_d;
  logic [OP_W-1:0]   ex_op_q, ex_op_d;
  logic [ADDR_W-1:0] ex_waddr_q, ex_waddr_d;
  logic [WIDTH-1:0]  ex_din_q, ex_din_d;
  logic [WIDTH-1:0]  ex_a_q, ex_a_d;
  logic [WIDTH-1:0]  ex_b_q, ex_b_d;

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  d_out_a_q, d_out_a_d;
  logic [WIDTH-1:0]  d_out_b_q, d_out_b_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              cout_q, cout_d;
  logic              zero_q, zero_d;

  logic [WIDTH-1:0]  alu_result;
  logic              alu_cout;
  logic              alu_zero;
  logic              wb_en;
  logic [WIDTH-1:0]  wb_data;
  logic [WIDTH-1:0]  rd_a;
  logic [WIDTH-1:0]  rd_b;

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .op     (ex_op_q),
    .a      (ex_a_q),
    .b      (ex_b_q),
    .result (alu_result),
    .cout   (alu_cout),
    .zero   (alu_zero)
  );

  always_comb begin
    wb_en   = ex_valid_q & ex_wr_q;
    wb_data = ex_sel_q ? alu_result : ex_din_q;

    // The stage-2 write lands at the same edge that latches these operands.
    rd_a = (wb_en && (ex_waddr_q == rd_addr_a)) ? wb_data : rf_q[rd_addr_a];
    rd_b = (wb_en && (ex_waddr_q == rd_addr_b)) ? wb_data : rf_q[rd_addr_b];

    ex_valid_d = in_valid;
    ex_sel_d   = ex_sel_q;
    ex_wr_d    = ex_wr_q;
    ex_op_d    = ex_op_q;
    ex_waddr_d = ex_waddr_q;
    ex_din_d   = ex_din_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    if (in_valid) begin
      ex_sel_d   = sel;
      ex_wr_d    = wr;
      ex_op_d    = op;
      ex_waddr_d = wr_addr;
      ex_din_d   = d_in;
      ex_a_d     = rd_a;
      ex_b_d     = rd_b;
    end

    rf_d = rf_q;
    if (wb_en) rf_d[ex_waddr_q] = wb_data;

    out_valid_d = ex_valid_q;
    d_out_a_d   = d_out_a_q;
    d_out_b_d   = d_out_b_q;
    result_d    = result_q;
    cout_d      = cout_q;
    zero_d      = zero_q;
    if (ex_valid_q) begin
      d_out_a_d = ex_a_q;
      d_out_b_d = ex_b_q;
      result_d  = alu_result;
      cout_d    = alu_cout;
      zero_d    = alu_zero;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_q        <= '{default: '0};
      ex_valid_q  <= 1'b0;
      ex_sel_q    <= 1'b0;
      ex_wr_q     <= 1'b0;
      ex_op_q     <= '0;
      ex_waddr_q  <= '0;
      ex_din_q    <= '0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      out_valid_q <= 1'b0;
      d_out_a_q   <= '0;
      d_out_b_q   <= '0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      rf_q        <= rf_d;
      ex_valid_q  <= ex_valid_d;
      ex_sel_q    <= ex_sel_d;
      ex_wr_q     <= ex_wr_d;
      ex_op_q     <= ex_op_d;
      ex_waddr_q  <= ex_waddr_d;
      ex_din_q    <= ex_din_d;
      ex_a_q      <= ex_a_d;
      ex_b_q      <= ex_b_d;
      out_valid_q <= out_valid_d;
      d_out_a_q   <= d_out_a_d;
      d_out_b_q   <= d_out_b_d;
      result_q    <= result_d;
      cout_q      <= cout_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign d_out_a   = d_out_a_q;
  assign d_out_b   = d_out_b_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_reg_alu_pipe.sv
// Directed bench for reg_alu_pipe: loads, forwarding, arithmetic/logic ops,
// mid-flight reset and bubbles, with hand-computed expectations.
module tb_reg_alu_pipe;
  import reg_alu_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        sel;
  logic        wr;
  logic [2:0]  op;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [2:0]  wr_addr;
  logic [15:0] d_in;
  logic        out_valid;
  logic [15:0] d_out_a;
  logic [15:0] d_out_b;
  logic [15:0] result;
  logic        cout;
  logic        zero;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  reg_alu_pipe #(.WIDTH(16), .ADDR_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .sel       (sel),
    .wr        (wr),
    .op        (op),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .wr_addr   (wr_addr),
    .d_in      (d_in),
    .out_valid (out_valid),
    .d_out_a   (d_out_a),
    .d_out_b   (d_out_b),
    .result    (result),
    .cout      (cout),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one issue slot, then advance to the next falling edge.
  task automatic issue(input logic v, input logic s, input logic w, input logic [2:0] o,
                       input logic [2:0] a, input logic [2:0] b, input logic [2:0] wa,
                       input logic [15:0] din);
    in_valid  = v;
    sel       = s;
    wr        = w;
    op        = o;
    rd_addr_a = a;
    rd_addr_b = b;
    wr_addr   = wa;
    d_in      = din;
    @(negedge clk);
  endtask

  task automatic load(input logic [2:0] wa, input logic [15:0] din);
    issue(1'b1, 1'b0, 1'b1, OP_PASS, 3'd0, 3'd0, wa, din);
  endtask

  task automatic idle();
    issue(1'b0, 1'b0, 1'b0, OP_PASS, 3'd0, 3'd0, 3'd0, 16'h0000);
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0; sel = 1'b0; wr = 1'b0; op = '0;
    rd_addr_a = '0; rd_addr_b = '0; wr_addr = '0; d_in = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    reset = 1'b1;

    load(3'd3, 16'hcdef);
    load(3'd7, 16'h3210);
    issue(1'b1, 1'b0, 1'b0, OP_PASS, 3'd3, 3'd7, 3'd0, 16'h0000);
    issue(1'b1, 1'b1, 1'b1, OP_ADD, 3'd3, 3'd7, 3'd2, 16'h0000);
    check("pass_valid", {31'd0, out_valid}, 32'd1);
    check("pass_a", {16'd0, d_out_a}, 32'h0000cdef);
    check("pass_b", {16'd0, d_out_b}, 32'h00003210);
    check("pass_res", {16'd0, result}, 32'h0000cdef);

    issue(1'b1, 1'b0, 1'b0, OP_PASS, 3'd2, 3'd2, 3'd0, 16'h0000);
    check("add_res", {16'd0, result}, 32'h0000ffff);
    check("add_cout", {31'd0, cout}, 32'd0);
    check("add_zero", {31'd0, zero}, 32'd0);

    issue(1'b1, 1'b0, 1'b0, OP_SUB, 3'd7, 3'd3, 3'd0, 16'h0000);
    check("fwd_a", {16'd0, d_out_a}, 32'h0000ffff);
    check("fwd_b", {16'd0, d_out_b}, 32'h0000ffff);

    issue(1'b1, 1'b0, 1'b0, OP_SUB, 3'd3, 3'd7, 3'd0, 16'h0000);
    check("sub1_res", {16'd0, result}, 32'h00006421);
    check("sub1_cout", {31'd0, cout}, 32'd0);

    idle();
    check("sub2_res", {16'd0, result}, 32'h00009bdf);
    check("sub2_cout", {31'd0, cout}, 32'd1);

    idle();
    check("idle_valid", {31'd0, out_valid}, 32'd0);
    check("idle_hold_res", {16'd0, result}, 32'h00009bdf);
    check("idle_hold_cout", {31'd0, cout}, 32'd1);

    load(3'd1, 16'hffff);
    load(3'd4, 16'h0001);
    load(3'd0, 16'h0011);
    issue(1'b1, 1'b0, 1'b0, OP_ADD, 3'd1, 3'd4, 3'd0, 16'h0000);
    issue(1'b1, 1'b0, 1'b0, OP_SHL, 3'd4, 3'd0, 3'd0, 16'h0000);
    check("wrap_res", {16'd0, result}, 32'h00000000);
    check("wrap_cout", {31'd0, cout}, 32'd1);
    check("wrap_zero", {31'd0, zero}, 32'd1);

    issue(1'b1, 1'b0, 1'b0, OP_AND, 3'd3, 3'd7, 3'd0, 16'h0000);
    check("shl_res", {16'd0, result}, 32'h00000002);
    check("shl_b", {16'd0, d_out_b}, 32'h00000011);
    check("shl_cout", {31'd0, cout}, 32'd0);
    check("shl_zero", {31'd0, zero}, 32'd0);

    issue(1'b1, 1'b0, 1'b0, OP_OR, 3'd3, 3'd7, 3'd0, 16'h0000);
    check("and_res", {16'd0, result}, 32'h00000000);
    check("and_zero", {31'd0, zero}, 32'd1);

    issue(1'b1, 1'b0, 1'b0, OP_XOR, 3'd3, 3'd7, 3'd0, 16'h0000);
    check("or_res", {16'd0, result}, 32'h0000ffff);

    issue(1'b1, 1'b0, 1'b0, OP_SHR, 3'd3, 3'd4, 3'd0, 16'h0000);
    check("xor_res", {16'd0, result}, 32'h0000ffff);

    load(3'd5, 16'habcd);
    check("shr_res", {16'd0, result}, 32'h000066f7);
    check("shr_valid", {31'd0, out_valid}, 32'd1);

    // Write to r5 is still in stage 2 here.
    reset = 1'b0;
    #1;
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_res", {16'd0, result}, 32'd0);
    check("mrst_a", {16'd0, d_out_a}, 32'd0);
    check("mrst_b", {16'd0, d_out_b}, 32'd0);
    check("mrst_cout", {31'd0, cout}, 32'd0);
    check("mrst_zero", {31'd0, zero}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mrst_hold_valid", {31'd0, out_valid}, 32'd0);
    end
    reset = 1'b1;

    issue(1'b1, 1'b0, 1'b0, OP_PASS, 3'd5, 3'd1, 3'd0, 16'h0000);
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    load(3'd6, 16'h1234);
    check("r5_cleared", {16'd0, d_out_a}, 32'd0);
    check("r1_cleared", {16'd0, d_out_b}, 32'd0);
    check("r5_zero", {31'd0, zero}, 32'd1);
    check("r5_valid", {31'd0, out_valid}, 32'd1);

    issue(1'b1, 1'b0, 1'b0, OP_PASS, 3'd6, 3'd6, 3'd0, 16'h0000);
    issue(1'b0, 1'b0, 1'b1, OP_PASS, 3'd0, 3'd0, 3'd6, 16'hbeef);
    check("r6_pass", {16'd0, d_out_a}, 32'h00001234);
    idle();
    check("bub_valid", {31'd0, out_valid}, 32'd0);
    check("bub_hold_a", {16'd0, d_out_a}, 32'h00001234);
    check("bub_hold_res", {16'd0, result}, 32'h00001234);
    issue(1'b1, 1'b0, 1'b0, OP_PASS, 3'd6, 3'd6, 3'd0, 16'h0000);
    idle();
    check("bub_nowrite", {16'd0, d_out_a}, 32'h00001234);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_alu_pipe.md
# reg_alu_pipe

Parametrised, pipelined successor to the 8×16 register-file/ALU block. It holds a `DEPTH`×`WIDTH` register file with two read ports and one write port, and feeds an eight-operation ALU. Write-back comes from either the ALU result or external `d_in`. Both operand reads and the write-back are pipelined over two stages, with full forwarding, so back-to-back dependent operations issue every cycle without stalls. It sits between the instruction sequencer and the datapath output mux.

## Interface
- `WIDTH`, 16: data width; must be ≥ 4.
- `ADDR_W`, 3: register address width; `DEPTH = 2**ADDR_W`.
- `OP_W`, 3: opcode width (fixed encoding from the package).

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  issue qualifier; all other inputs are sampled only when it is 1.
- `sel`  in  1  write-back source: 1 = ALU result, 0 = `d_in`.
- `wr`  in  1  write enable for this operation.
- `op`  in  OP_W  ALU operation.
- `rd_addr_a`, `rd_addr_b`  in  ADDR_W  operand A/B addresses.
- `wr_addr`  in  ADDR_W  destination address.
- `d_in`  in  WIDTH  external write data.
- `out_valid`  out  1  one-cycle pulse per completed operation.
- `d_out_a`, `d_out_b`  out  WIDTH  operand values used by the completed operation.
- `result`  out  WIDTH  ALU result.
- `cout`  out  1  carry / no-borrow flag.
- `zero`  out  1  1 when `result == 0`.

## Operation
- **Stage 1 (issue cycle N, `in_valid` = 1):**
  - Read A and B from the register file.
  - If a write-back to the same address commits at the end of cycle N, forward that write data instead of the stored value.
  - Latch operands and control into the EX registers at the end of N.
- **Stage 2 (cycle N+1):**
  - The ALU evaluates the latched operands.
  - At the end of N+1, register `result`, `cout`, `zero`, `d_out_a` and `d_out_b`.
  - At the same edge, if `wr` = 1, write `sel ? result : d_in` to `wr_addr`.
- **Opcode encoding** (in `op`):
  - 0 ADD: `{cout,result} = A+B`.
  - 1 SUB: `result = A-B`; `cout` = 1 iff A ≥ B (unsigned).
  - 2 AND, 3 OR, 4 XOR.
  - 5 SHL: `A << B[$clog2(WIDTH)-1:0]`.
  - 6 SHR (logical): same shift-amount rule as SHL.
  - 7 PASS: `result = A`.
- `cout` = 0 for every op other than ADD and SUB.
- All arithmetic is unsigned and modulo 2^WIDTH.
- The ALU runs regardless of `sel`/`wr`; `wr` = 0 still produces `out_valid`.
- `in_valid` = 0 inserts a bubble: no write, and outputs hold their last values.
- Register 0 is an ordinary register; it is not hardwired to zero.
- An operation that reads its own `wr_addr` sees the pre-write value.

## Timing
- Latency: issue in cycle N → `out_valid` and all outputs valid in cycle N+2, and the register updated from N+2 onward.
- Throughput: one operation per cycle.
- Forwarding: an operation issued in cycle N+1 that reads the destination written by an operation issued in N gets the new value. Both ports forward independently.
- Reset (`reset` low, any time):
  - Every register-file entry, pipeline register and output clears to 0 asynchronously; `out_valid` = 0.
  - In-flight operations are discarded with no write-back.
  - The first issue is sampled at the first rising edge with `reset` high.
- Simultaneous A/B reads of the same address both return the same (possibly forwarded) value.

## Structure
- Package `reg_alu_pkg`: opcode localparams `OP_ADD … OP_PASS`, `OP_W`.
- Sub-module `alu_core`: purely combinational, parametrised by `WIDTH`, producing `result`, `cout`, `zero`.
- Register file, forwarding muxes and pipeline registers stay in `reg_alu_pipe`.

## Test plan
Defaults: WIDTH=16, ADDR_W=3.
- Reset, then issue sel0 wr1 `d_in`=16'hcdef → r3, then 16'h3210 → r7, then PASS a=r3 b=r7 → `d_out_a`=cdef, `d_out_b`=3210, each at issue+2.
- Back-to-back: ADD r3+r7 → r2 with sel1 wr1, then immediately PASS a=r2 → first `result`=ffff with `cout`=0; second `d_out_a`=ffff via forwarding.
- SUB r7−r3 → `result`=16'h6421, `cout`=0. SUB r3−r7 → `result`=16'h9bdf, `cout`=1.
- Load ffff into r1 and 0001 into r4, then ADD r1+r4 → `result`=0000, `cout`=1, `zero`=1. SHL r4 by B=17 → `result`=0002.
- Issue a wr1 op to r5, then assert reset in the following cycle (stage 2) → r5 reads 0 after reset, `out_valid` never pulses, and all outputs are 0.
- Issue with `in_valid`=0 and wr1 to r6 → r6 unchanged, no `out_valid`, and outputs hold their previous values.
